// File: rtl/full_adder_bist.sv
// Stimulus/response BIST engine for a 1-bit full adder.
// Sweeps all {a,b,cin} vectors, compares sum/cout against golden, counts mismatches.
module full_adder_bist #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             cin_o,
   input  logic             sum_i,
   input  logic             cout_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_vec
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       vec, vec_nxt;
   logic [PW-1:0]    pidx, pidx_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic             ffv_nxt;
   logic [2:0]       ffvec_nxt;
   logic [2:0]       drv, drv_nxt;
   logic             exp_sum, exp_cout, mism;

   assign exp_sum  = ^vec;
   assign exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
   assign mism     = (sum_i != exp_sum) | (cout_i != exp_cout);

   assign {a_o, b_o, cin_o} = drv;

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec;
      pidx_nxt  = pidx;
      cnt_nxt   = cnt;
      err_nxt   = err_count;
      ffv_nxt   = first_fail_valid;
      ffvec_nxt = first_fail_vec;
      drv_nxt   = drv;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               err_nxt   = '0;
               ffv_nxt   = 1'b0;
               ffvec_nxt = 3'd0;
               vec_nxt   = 3'd0;
               pidx_nxt  = '0;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            drv_nxt   = vec;
            cnt_nxt   = CW'(SETTLE_CYCLES - 1);
            state_nxt = SETTLE;
         end
         SETTLE: begin
            if (cnt == '0) state_nxt = SAMPLE;
            else cnt_nxt = cnt - CW'(1);
         end
         SAMPLE: begin
            if (mism) begin
               if (err_count != '1) err_nxt = err_count + ERR_W'(1);
               if (!first_fail_valid) begin
                  ffv_nxt   = 1'b1;
                  ffvec_nxt = vec;
               end
            end
            if (vec == 3'd7 && pidx == PW'(PASSES - 1)) begin
               state_nxt = DONE;
            end else begin
               vec_nxt = vec + 3'd1;
               if (vec == 3'd7) pidx_nxt = pidx + PW'(1);
               state_nxt = DRIVE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status flags are registered from the next-state so they align with state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         vec              <= 3'd0;
         pidx             <= '0;
         cnt              <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= 3'd0;
         drv              <= 3'd0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
      end else begin
         state            <= state_nxt;
         vec              <= vec_nxt;
         pidx             <= pidx_nxt;
         cnt              <= cnt_nxt;
         err_count        <= err_nxt;
         first_fail_valid <= ffv_nxt;
         first_fail_vec   <= ffvec_nxt;
         drv              <= drv_nxt;
         busy             <= (state_nxt == DRIVE) || (state_nxt == SETTLE) ||
                             (state_nxt == SAMPLE);
         done             <= (state_nxt == DONE);
         pass             <= (state_nxt == DONE) && (err_nxt == '0);
      end
   end

endmodule

// File: tb/tb_full_adder_bist.sv
// Directed bench for full_adder_bist: three engines beside behavioural adders
// (good/stuck-cout, inverted-sum with 3 passes, good with 1 settle cycle).
module tb_full_adder_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] st = 3'b000;
   int mode = 0;
   int checks = 0;
   int errors = 0;
   bit busy_ok, stable_ok;
   int n;

   logic       a0, b0, c0, s0, co0, bz0, dn0, ps0, fv0;
   logic [3:0] e0;
   logic [2:0] fvec0;
   logic       a1, b1, c1, s1, co1, bz1, dn1, ps1, fv1;
   logic [3:0] e1;
   logic [2:0] fvec1;
   logic       a2, b2, c2, s2, co2, bz2, dn2, ps2, fv2;
   logic [3:0] e2;
   logic [2:0] fvec2;

   always #5 clk = ~clk;

   assign s0  = a0 ^ b0 ^ c0;
   assign co0 = (mode == 1) ? 1'b0 : ((a0 & b0) | (a0 & c0) | (b0 & c0));
   assign s1  = ~(a1 ^ b1 ^ c1);
   assign co1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
   assign s2  = a2 ^ b2 ^ c2;
   assign co2 = (a2 & b2) | (a2 & c2) | (b2 & c2);

   full_adder_bist u0 (
      .clk(clk), .rst_n(rst_n), .start(st[0]),
      .a_o(a0), .b_o(b0), .cin_o(c0), .sum_i(s0), .cout_i(co0),
      .busy(bz0), .done(dn0), .pass(ps0), .err_count(e0),
      .first_fail_valid(fv0), .first_fail_vec(fvec0));

   full_adder_bist #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]),
      .a_o(a1), .b_o(b1), .cin_o(c1), .sum_i(s1), .cout_i(co1),
      .busy(bz1), .done(dn1), .pass(ps1), .err_count(e1),
      .first_fail_valid(fv1), .first_fail_vec(fvec1));

   full_adder_bist #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u2 (
      .clk(clk), .rst_n(rst_n), .start(st[2]),
      .a_o(a2), .b_o(b2), .cin_o(c2), .sum_i(s2), .cout_i(co2),
      .busy(bz2), .done(dn2), .pass(ps2), .err_count(e2),
      .first_fail_valid(fv2), .first_fail_vec(fvec2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic dn_v(input int sel);
      return (sel == 0) ? dn0 : (sel == 1) ? dn1 : dn2;
   endfunction

   function automatic logic bz_v(input int sel);
      return (sel == 0) ? bz0 : (sel == 1) ? bz1 : bz2;
   endfunction

   function automatic logic [2:0] abc_v(input int sel);
      return (sel == 0) ? {a0, b0, c0} : (sel == 1) ? {a1, b1, c1} : {a2, b2, c2};
   endfunction

   // Pulse start, then count edges after the sampling edge until done.
   // Start is re-driven high on edges hs..he-1 to exercise start-while-busy.
   task automatic run(input int sel, input int hs, input int he, output int cnt);
      int s;
      logic [2:0] ev;
      s = (sel == 2) ? 1 : 2;
      busy_ok = 1'b1;
      stable_ok = 1'b1;
      cnt = 0;
      @(negedge clk) st[sel] = 1'b1;
      @(negedge clk) st[sel] = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (dn_v(sel)) begin
            cnt = i;
            break;
         end
         if (!bz_v(sel)) busy_ok = 1'b0;
         ev = 3'((i - 1) / (s + 2));
         if (abc_v(sel) !== ev) stable_ok = 1'b0;
         @(negedge clk) st[sel] = (i >= hs && i < he);
      end
      st[sel] = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", bz0, 0);
      chk("rst_done", dn0, 0);
      chk("rst_pass", ps0, 0);
      chk("rst_err", e0, 0);
      chk("rst_abc", {a0, b0, c0}, 0);
      chk("rst_ffv", fv0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", bz0, 0);

      // T1: good adder, 32-cycle run
      run(0, 0, 0, n);
      chk("t1_cycles", n, 32);
      chk("t1_busy_hold", busy_ok, 1);
      chk("t1_vec_seq", stable_ok, 1);
      chk("t1_busy_end", bz0, 0);
      chk("t1_pass", ps0, 1);
      chk("t1_err", e0, 0);
      chk("t1_ffv", fv0, 0);
      chk("t1_abc_hold", {a0, b0, c0}, 3'b111);

      // T2: cout stuck at 0
      mode = 1;
      run(0, 0, 0, n);
      chk("t2_cycles", n, 32);
      chk("t2_pass", ps0, 0);
      chk("t2_err", e0, 4);
      chk("t2_ffv", fv0, 1);
      chk("t2_ffvec", fvec0, 3'b011);
      repeat (3) @(negedge clk);
      chk("t2_done_hold", dn0, 1);

      // T5b: start from DONE reruns and clears result
      mode = 0;
      @(negedge clk) st[0] = 1'b1;
      @(negedge clk) st[0] = 1'b0;
      chk("t5_rst_done", dn0, 0);
      chk("t5_rst_err", e0, 0);
      chk("t5_rst_ffv", fv0, 0);
      chk("t5_rst_busy", bz0, 1);
      repeat (40) @(negedge clk);
      chk("t5_rerun_pass", ps0, 1);

      // T5a: start held 10 cycles mid-run
      run(0, 5, 15, n);
      chk("t5_hold_cycles", n, 32);
      chk("t5_hold_busy", busy_ok, 1);
      chk("t5_hold_pass", ps0, 1);

      // T4: reset during SETTLE of vector 5 with a failing adder
      mode = 1;
      @(negedge clk) st[0] = 1'b1;
      @(negedge clk) st[0] = 1'b0;
      repeat (21) @(posedge clk);
      @(negedge clk);
      chk("t4_pre_err", e0, 1);
      chk("t4_pre_abc", {a0, b0, c0}, 3'b101);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_busy", bz0, 0);
      chk("t4_done", dn0, 0);
      chk("t4_pass", ps0, 0);
      chk("t4_err", e0, 0);
      chk("t4_ffv", fv0, 0);
      chk("t4_ffvec", fvec0, 0);
      chk("t4_abc", {a0, b0, c0}, 0);
      @(negedge clk) rst_n = 1'b1;
      mode = 0;
      repeat (3) @(negedge clk);
      chk("t4_idle", {bz0, dn0}, 0);
      run(0, 0, 0, n);
      chk("t4_run_cycles", n, 32);
      chk("t4_run_pass", ps0, 1);
      chk("t4_run_ffv", fv0, 0);

      // T3: sum inverted, 3 passes, counter saturates
      run(1, 0, 0, n);
      chk("t3_cycles", n, 96);
      chk("t3_vec_seq", stable_ok, 1);
      chk("t3_err", e1, 15);
      chk("t3_pass", ps1, 0);
      chk("t3_ffv", fv1, 1);
      chk("t3_ffvec", fvec1, 3'b000);

      // T6: one settle cycle
      run(2, 0, 0, n);
      chk("t6_cycles", n, 24);
      chk("t6_stable", stable_ok, 1);
      chk("t6_busy_hold", busy_ok, 1);
      chk("t6_pass", ps2, 1);
      chk("t6_err", e2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
